// File: rtl/ifex_ctrl_pkg.sv
// Shared types and ex-bus address helpers for the ifex launch controller.
package ifex_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT
  } state_t;

  // EXSEL code that routes an ex-bus access to the core's instruction memory.
  localparam int unsigned EX_IMEM_CODE = 0;

  // Build an ex-bus address: EXSEL in the MSBs, word address below it.
  function automatic logic [31:0] exa_pack(input int unsigned sel,
                                           input int unsigned addr,
                                           input int unsigned insta_w);
    return 32'((sel << insta_w) | addr);
  endfunction

  // Extract the EXSEL field from an ex-bus address.
  function automatic logic [31:0] exsel_of(input logic [31:0] exa,
                                           input int unsigned insta_w);
    return exa >> insta_w;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // Count up on enable, hold at all-ones; clear takes priority.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/ifex_launch_ctrl.sv
// Host-side sequencer for one ifex core: loads imem over the ex bus,
// starts the core, waits for done or timeout, then hands the bus back.
module ifex_launch_ctrl
  import ifex_ctrl_pkg::*;
#(
  parameter int unsigned CPU_W   = 16,
  parameter int unsigned EXA_W   = 8,
  parameter int unsigned INSTA_W = 6,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned EX_IMEM = EX_IMEM_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic [INSTA_W:0]   cfg_len,
  input  logic [TMO_W-1:0]   cfg_tmo,
  input  logic               s_valid,
  input  logic [CPU_W-1:0]   s_data,
  output logic               s_ready,
  input  logic               host_we,
  input  logic               host_re,
  input  logic [EXA_W-1:0]   host_a,
  input  logic [CPU_W-1:0]   host_wd,
  output logic [CPU_W-1:0]   host_rd,
  output logic               host_gnt,
  output logic               o_run,
  output logic               o_exwe,
  output logic               o_exre,
  output logic [EXA_W-1:0]   o_exa,
  output logic [CPU_W-1:0]   o_exwd,
  input  logic [CPU_W-1:0]   i_exrd,
  input  logic               i_done,
  output logic               o_busy,
  output logic               o_fin,
  output logic               o_tmo,
  output logic [TMO_W-1:0]   o_cycles
);

  localparam logic [INSTA_W:0] DEPTH   = {1'b1, {INSTA_W{1'b0}}};
  localparam logic [INSTA_W:0] ADDR_1  = (INSTA_W+1)'(1);
  localparam logic [TMO_W:0]   CYC_1   = (TMO_W+1)'(1);

  state_t state, state_nx;

  logic [INSTA_W:0] len_q;
  logic [TMO_W-1:0] tmo_q;
  logic [INSTA_W:0] addr;
  logic             ld_we;
  logic [EXA_W-1:0] ld_a;
  logic [CPU_W-1:0] ld_wd;
  logic             run_q;
  logic             fin_q;
  logic             tmo_flag;

  logic start_ok;
  logic load_acc;
  logic load_last;
  logic done_hit;
  logic tmo_hit;
  logic cyc_en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: abort overrides everything, done beats timeout in WAIT.
  always_comb begin
    state_nx = state;
    if (cfg_abort) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (cfg_start) state_nx = S_LOAD;
        S_LOAD: if ((len_q == '0) || load_last) state_nx = S_RUN;
        S_RUN:  state_nx = S_WAIT;
        S_WAIT: if (done_hit || tmo_hit) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Outputs and decode: host owns the bus in IDLE unless a start arrives,
  // otherwise the bus carries the registered loader write.
  always_comb begin
    start_ok  = (state == S_IDLE) && cfg_start && !cfg_abort;
    s_ready   = (state == S_LOAD) && !cfg_abort;
    load_acc  = s_valid && s_ready;
    load_last = load_acc && ((addr + ADDR_1) == len_q);
    done_hit  = (state == S_WAIT) && i_done;
    tmo_hit   = (state == S_WAIT) && !i_done && (tmo_q != '0) &&
                (({1'b0, o_cycles} + CYC_1) == {1'b0, tmo_q});
    cyc_en    = (state == S_WAIT);
    host_gnt  = (state == S_IDLE) && !cfg_start;
    o_busy    = (state != S_IDLE);
    host_rd   = i_exrd;
    o_run     = run_q;
    o_fin     = fin_q;
    o_tmo     = tmo_flag;
    if (state == S_IDLE) begin
      o_exwe = host_we && host_gnt;
      o_exre = host_re && host_gnt;
      o_exa  = host_a;
      o_exwd = host_wd;
    end else begin
      o_exwe = ld_we;
      o_exre = 1'b0;
      o_exa  = ld_a;
      o_exwd = ld_wd;
    end
  end

  // Loader, run handshake and status registers. o_run follows the next
  // state so it rises only after the final imem write has left the bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      tmo_q    <= '0;
      addr     <= '0;
      ld_we    <= 1'b0;
      ld_a     <= '0;
      ld_wd    <= '0;
      run_q    <= 1'b0;
      fin_q    <= 1'b0;
      tmo_flag <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q <= (cfg_len > DEPTH) ? DEPTH : cfg_len;
        tmo_q <= cfg_tmo;
        addr  <= '0;
      end
      ld_we <= load_acc;
      if (load_acc) begin
        ld_a  <= EXA_W'(exa_pack(EX_IMEM, 32'(addr[INSTA_W-1:0]), INSTA_W));
        ld_wd <= s_data;
        addr  <= addr + ADDR_1;
      end
      run_q <= (state_nx == S_WAIT);
      fin_q <= done_hit && !cfg_abort;
      if (start_ok) begin
        tmo_flag <= 1'b0;
      end else if (tmo_hit && !cfg_abort) begin
        tmo_flag <= 1'b1;
      end
    end
  end

  sat_cnt #(.W(TMO_W)) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (start_ok),
    .en  (cyc_en),
    .q   (o_cycles)
  );

endmodule

// File: tb/tb_ifex_launch_ctrl.sv
// Directed-with-random-data bench for ifex_launch_ctrl with a behavioural
// imem/core model and expected-image scoreboard.
module tb_ifex_launch_ctrl;

  localparam int CPU_W   = 16;
  localparam int EXA_W   = 8;
  localparam int INSTA_W = 6;
  localparam int TMO_W   = 16;
  localparam int EX_IMEM = 0;
  localparam int DEPTH   = 1 << INSTA_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_start, cfg_abort;
  logic [INSTA_W:0]   cfg_len;
  logic [TMO_W-1:0]   cfg_tmo;
  logic               s_valid;
  logic [CPU_W-1:0]   s_data;
  logic               s_ready;
  logic               host_we, host_re;
  logic [EXA_W-1:0]   host_a;
  logic [CPU_W-1:0]   host_wd, host_rd;
  logic               host_gnt;
  logic               o_run, o_exwe, o_exre;
  logic [EXA_W-1:0]   o_exa;
  logic [CPU_W-1:0]   o_exwd;
  logic [CPU_W-1:0]   i_exrd;
  logic               i_done;
  logic               o_busy, o_fin, o_tmo;
  logic [TMO_W-1:0]   o_cycles;

  ifex_launch_ctrl #(
    .CPU_W(CPU_W), .EXA_W(EXA_W), .INSTA_W(INSTA_W), .TMO_W(TMO_W), .EX_IMEM(EX_IMEM)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_len(cfg_len), .cfg_tmo(cfg_tmo), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .host_we(host_we), .host_re(host_re), .host_a(host_a),
    .host_wd(host_wd), .host_rd(host_rd), .host_gnt(host_gnt), .o_run(o_run),
    .o_exwe(o_exwe), .o_exre(o_exre), .o_exa(o_exa), .o_exwd(o_exwd),
    .i_exrd(i_exrd), .i_done(i_done), .o_busy(o_busy), .o_fin(o_fin),
    .o_tmo(o_tmo), .o_cycles(o_cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference state: imem contents, expected image, run bookkeeping.
  logic [CPU_W-1:0] mem [DEPTH];
  logic [CPU_W-1:0] sq [$];
  logic [CPU_W-1:0] exp_img [$];
  int wr_cycs [$];
  int cyc = 0;
  int load_idx = 0;
  int run_rise_cyc = 0;
  int run_edges = 0;
  int fin_cnt = 0;
  int run_cnt = 0;
  int done_after = 0;
  bit gaps = 0;
  logic run_prev = 1'b0;

  // Core model: signals done once it has been running done_after cycles.
  assign i_done = (done_after != 0) && (run_cnt >= done_after);

  // Stream source: pops on handshake, optionally inserts random bubbles.
  always @(posedge clk) begin
    if (s_valid && s_ready && sq.size() > 0) void'(sq.pop_front());
    #1;
    s_valid = (sq.size() > 0) && (!gaps || $urandom_range(0, 2) != 0);
    s_data  = (sq.size() > 0) ? sq[0] : '0;
  end

  // Bus monitor / imem model.
  always @(posedge clk) begin
    cyc++;
    if (o_exwe === 1'b1) begin
      if (host_gnt === 1'b1) begin
        mem[o_exa[INSTA_W-1:0]] = o_exwd;
      end else begin
        check("ld_addr", 32'(o_exa), 32'((EX_IMEM << INSTA_W) | load_idx));
        if (load_idx < exp_img.size()) check("ld_data", 32'(o_exwd), 32'(exp_img[load_idx]));
        else check("ld_extra_write", load_idx, exp_img.size());
        mem[o_exa[INSTA_W-1:0]] = o_exwd;
        wr_cycs.push_back(cyc);
        load_idx++;
      end
    end
    if (o_run === 1'b1 && run_prev !== 1'b1) run_rise_cyc = cyc;
    run_prev = o_run;
    if (o_run === 1'b1) run_edges++;
    if (o_fin === 1'b1) fin_cnt++;
    run_cnt <= (o_run === 1'b1) ? run_cnt + 1 : 0;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input int len, input int tmo, input int dafter,
                           input bit gap, input bit fixed, input int n_feed);
    logic [CPU_W-1:0] w;
    sq.delete();
    exp_img.delete();
    for (int i = 0; i < len; i++) begin
      w = fixed ? (16'h00A1 + 16'(i) * 16'h0011) : CPU_W'($urandom);
      if (i < n_feed) sq.push_back(w);
      if (i < DEPTH) exp_img.push_back(w);
    end
    gaps = gap;
    done_after = dafter;
    load_idx = 0;
    wr_cycs.delete();
    run_edges = 0;
    fin_cnt = 0;
    cfg_len = (INSTA_W+1)'(len);
    cfg_tmo = TMO_W'(tmo);
    cfg_start = 1'b1;
    #1;
    check("start_gnt", host_gnt, 0);
    check("start_exwe", o_exwe, 0);
    tick();
    cfg_start = 1'b0;
    check("start_busy", o_busy, 1);
    check("start_sready", s_ready, 1);
    check("start_tmo_clr", o_tmo, 0);
    check("start_cyc_clr", o_cycles, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (o_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_budget", o_busy, 0);
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < exp_img.size(); i++) if (mem[i] !== exp_img[i]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CPU_W-1:0] pre [3];
    int n;
    rst = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_len = '0; cfg_tmo = '0;
    s_valid = 0; s_data = '0; host_we = 0; host_re = 0; host_a = '0; host_wd = '0;
    i_exrd = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state.
    check("rst_busy", o_busy, 0);
    check("rst_run", o_run, 0);
    check("rst_sready", s_ready, 0);
    check("rst_fin", o_fin, 0);
    check("rst_tmo", o_tmo, 0);
    check("rst_cycles", o_cycles, 0);
    check("rst_gnt", host_gnt, 1);
    check("rst_exwe", o_exwe, 0);

    // Host pass-through in IDLE.
    for (int k = 0; k < 4; k++) begin
      host_we = 1'($urandom); host_re = 1'($urandom);
      host_a = EXA_W'($urandom); host_wd = CPU_W'($urandom); i_exrd = CPU_W'($urandom);
      #1;
      check("pt_exwe", o_exwe, host_we);
      check("pt_exre", o_exre, host_re);
      check("pt_exa", o_exa, host_a);
      check("pt_exwd", o_exwd, host_wd);
      check("pt_rd", host_rd, i_exrd);
      tick();
    end
    host_we = 0; host_re = 0;
    tick();

    // 1/2: three fixed words, done after 10 running cycles.
    start_run(3, 0, 10, 0, 1, 3);
    wait_idle(200);
    check("t1_writes", load_idx, 3);
    check("t1_consec", (wr_cycs.size() == 3) ? wr_cycs[2] - wr_cycs[0] : -1, 2);
    check("t1_run_rise", run_rise_cyc, (wr_cycs.size() == 3) ? wr_cycs[2] + 1 : -1);
    check("t1_fin_pulse", o_fin, 1);
    check("t1_run_low", o_run, 0);
    check("t1_cycles_const", o_cycles, 11);
    check("t1_cycles_model", o_cycles, run_edges);
    check_image("t1_image");
    tick();
    check("t1_fin_once", o_fin, 0);
    check("t1_fin_cnt", fin_cnt, 1);
    check("t1_tmo", o_tmo, 0);

    // 3: never-ending program, timeout 20, stream with bubbles.
    n = $urandom_range(1, 8);
    start_run(n, 20, 0, 1, 0, n);
    wait_idle(400);
    check("t3_tmo", o_tmo, 1);
    check("t3_cycles", o_cycles, 20);
    check("t3_cycles_model", o_cycles, run_edges);
    check("t3_run", o_run, 0);
    check("t3_writes", load_idx, n);
    check_image("t3_image");
    tick();
    check("t3_no_fin", fin_cnt, 0);
    check("t3_tmo_sticky", o_tmo, 1);

    // 4: host write colliding with start; host write kept high through the run.
    host_we = 1'b1; host_a = EXA_W'(DEPTH - 1); host_wd = 16'hDEAD;
    n = $urandom_range(2, 6);
    start_run(n, 0, 5, 1, 0, n);
    wait_idle(200);
    host_we = 1'b0;
    check("t4_writes", load_idx, n);
    check("t4_cycles", o_cycles, 6);
    check_image("t4_image");
    tick();
    check("t4_fin_cnt", fin_cnt, 1);

    // 5: abort after 2 of 5 words, then restart from address 0.
    start_run(5, 0, 5, 0, 0, 2);
    n = 0;
    while (sq.size() > 0 && n < 50) begin tick(); n++; end
    tick();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    check("t5_sready", s_ready, 0);
    check("t5_busy", o_busy, 0);
    check("t5_run", o_run, 0);
    check("t5_partial", load_idx, 2);
    repeat (3) tick();
    check("t5_no_fin", fin_cnt, 0);
    check("t5_tmo", o_tmo, 0);
    start_run(4, 0, 6, 1, 0, 4);
    wait_idle(200);
    check("t5_rewrites", load_idx, 4);
    check_image("t5_image");
    tick();
    check("t5_fin", fin_cnt, 1);

    // 6: len=0 after host preload; no loader writes, imem untouched.
    for (int i = 0; i < 3; i++) begin
      pre[i] = CPU_W'($urandom);
      host_we = 1'b1; host_a = EXA_W'((EX_IMEM << INSTA_W) | i); host_wd = pre[i];
      tick();
    end
    host_we = 1'b0;
    start_run(0, 0, 3, 0, 0, 0);
    wait_idle(100);
    check("t6_no_writes", load_idx, 0);
    check("t6_cycles", o_cycles, 4);
    tick();
    check("t6_fin", fin_cnt, 1);
    n = 0;
    for (int i = 0; i < 3; i++) if (mem[i] !== pre[i]) n++;
    check("t6_preload", n, 0);

    // Length clamp with bubbles: 70 requested, 64 loaded, 6 left unconsumed.
    start_run(70, 0, 2, 1, 0, 70);
    wait_idle(1000);
    check("clamp_writes", load_idx, DEPTH);
    check("clamp_left", sq.size(), 6);
    check_image("clamp_image");
    sq.delete();
    tick();
    check("clamp_fin", fin_cnt, 1);

    // Done and timeout on the same cycle: done wins.
    start_run(1, 8, 7, 0, 0, 1);
    wait_idle(100);
    check("tie_fin", o_fin, 1);
    check("tie_tmo", o_tmo, 0);
    check("tie_cycles", o_cycles, 8);
    tick();

    // Start and abort together: abort wins.
    cfg_start = 1'b1; cfg_abort = 1'b1; cfg_len = 7'd3;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    check("sa_busy", o_busy, 0);

    // Reset mid-LOAD returns cleanly to IDLE.
    start_run(10, 0, 0, 0, 0, 10);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sq.delete();
    check("rl_busy", o_busy, 0);
    check("rl_sready", s_ready, 0);
    check("rl_run", o_run, 0);
    check("rl_cycles", o_cycles, 0);
    check("rl_gnt", host_gnt, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
